// File: rtl/regfile_pkg.sv
// Shared widths and entry type for the register-file write path.
package regfile_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] wreg;
        logic [DATA_W-1:0] wdata;
        logic              kill;
    } wb_entry_t;

endpackage

// File: rtl/aux_wb_fifo.sv
// Auxiliary writeback queue: storage, per-entry valid/kill bits, kill-by-address
// and pending lookup for two read ports.
module aux_wb_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [ADDR_W-1:0]          push_wreg,
    input  logic [DATA_W-1:0]          push_wdata,
    input  logic                       pop,
    input  logic                       kill_en,
    input  logic [ADDR_W-1:0]          kill_wreg,
    input  logic [ADDR_W-1:0]          rd_reg1,
    input  logic [ADDR_W-1:0]          rd_reg2,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [ADDR_W-1:0]          head_wreg,
    output logic [DATA_W-1:0]          head_wdata,
    output logic                       head_live,
    output logic                       rd1_pending,
    output logic                       rd2_pending
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] wreg_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  kill_q, kill_d;
    logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]   count_q;

    // A push lands in a slot that is never valid, so it cannot be killed this cycle.
    always_comb begin
        valid_d = valid_q;
        kill_d  = kill_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_en && valid_q[i] && (wreg_mem[i] == kill_wreg)) begin
                kill_d[i] = 1'b1;
            end
        end
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            kill_d[rd_ptr_q]  = 1'b0;
        end
        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            kill_d[wr_ptr_q]  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            kill_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q <= valid_d;
            kill_q  <= kill_d;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wreg_mem[wr_ptr_q] <= push_wreg;
            data_mem[wr_ptr_q] <= push_wdata;
        end
    end

    always_comb begin
        rd1_pending = 1'b0;
        rd2_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !kill_q[i]) begin
                if ((rd_reg1 != '0) && (wreg_mem[i] == rd_reg1)) rd1_pending = 1'b1;
                if ((rd_reg2 != '0) && (wreg_mem[i] == rd_reg2)) rd2_pending = 1'b1;
            end
        end
    end

    assign count      = count_q;
    assign head_wreg  = wreg_mem[rd_ptr_q];
    assign head_wdata = data_mem[rd_ptr_q];
    assign head_live  = (count_q != '0) && !kill_q[rd_ptr_q];

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the register-file write port between core writeback (priority) and a
// queued auxiliary path, with starvation protection and stale-result kill.
module regfile_wr_arbiter #(
    parameter int unsigned DATA_W     = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W     = regfile_pkg::ADDR_W,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       core_we,
    input  logic [ADDR_W-1:0]          core_wreg,
    input  logic [DATA_W-1:0]          core_wdata,
    output logic                       core_stall,
    input  logic                       aux_valid,
    output logic                       aux_ready,
    input  logic [ADDR_W-1:0]          aux_wreg,
    input  logic [DATA_W-1:0]          aux_wdata,
    input  logic [ADDR_W-1:0]          rd_reg1,
    input  logic [ADDR_W-1:0]          rd_reg2,
    output logic                       rd1_pending,
    output logic                       rd2_pending,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_wreg,
    output logic [DATA_W-1:0]          rf_wdata,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    import regfile_pkg::*;

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

    logic [CntW-1:0]   count;
    logic [ADDR_W-1:0] head_wreg;
    logic [DATA_W-1:0] head_wdata;
    logic              head_live;
    logic              fifo_empty, fifo_full;
    logic              core_req, starve_grant, core_grant, pop, push;
    logic [StW-1:0]    starve_q, starve_d;

    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == CntW'(DEPTH));
    assign core_req     = core_we && (core_wreg != ADDR_W'(REG_ZERO));
    assign starve_grant = (starve_q == StW'(STARVE_MAX)) && head_live;
    assign core_grant   = core_req && !starve_grant;
    // A killed head still drains when the core leaves the port idle.
    assign pop          = starve_grant || (!core_req && !fifo_empty);
    assign push         = aux_valid && !fifo_full && (aux_wreg != ADDR_W'(REG_ZERO));

    aux_wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_wreg   (aux_wreg),
        .push_wdata  (aux_wdata),
        .pop         (pop),
        .kill_en     (core_grant),
        .kill_wreg   (core_wreg),
        .rd_reg1     (rd_reg1),
        .rd_reg2     (rd_reg2),
        .count       (count),
        .head_wreg   (head_wreg),
        .head_wdata  (head_wdata),
        .head_live   (head_live),
        .rd1_pending (rd1_pending),
        .rd2_pending (rd2_pending)
    );

    always_comb begin
        starve_d = starve_q;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (core_grant && head_live && (starve_q != StW'(STARVE_MAX))) begin
            starve_d = starve_q + StW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_wreg  = core_wreg;
        rf_wdata = core_wdata;
        if (starve_grant) begin
            rf_we    = 1'b1;
            rf_wreg  = head_wreg;
            rf_wdata = head_wdata;
        end else if (core_req) begin
            rf_we = 1'b1;
        end else if (!fifo_empty) begin
            rf_we    = head_live;
            rf_wreg  = head_wreg;
            rf_wdata = head_wdata;
        end
        if (!rst_n) begin
            rf_we = 1'b0;
        end
    end

    assign core_stall = rst_n && starve_grant;
    assign aux_ready  = rst_n && !fifo_full;
    assign fifo_count = count;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_regfile_wr_arbiter;

    import regfile_pkg::*;

    localparam int unsigned DEPTH      = 4;
    localparam int unsigned STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_we, core_stall, aux_valid, aux_ready;
    logic [4:0]  core_wreg, aux_wreg, rd_reg1, rd_reg2, rf_wreg;
    logic [31:0] core_wdata, aux_wdata, rf_wdata;
    logic        rd1_pending, rd2_pending, rf_we;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] tb_rf [32];

    always #5 clk = ~clk;

    always @(posedge clk) if (rf_we) tb_rf[rf_wreg] <= rf_wdata;

    regfile_wr_arbiter #(
        .DATA_W     (32),
        .ADDR_W     (5),
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .core_we     (core_we),
        .core_wreg   (core_wreg),
        .core_wdata  (core_wdata),
        .core_stall  (core_stall),
        .aux_valid   (aux_valid),
        .aux_ready   (aux_ready),
        .aux_wreg    (aux_wreg),
        .aux_wdata   (aux_wdata),
        .rd_reg1     (rd_reg1),
        .rd_reg2     (rd_reg2),
        .rd1_pending (rd1_pending),
        .rd2_pending (rd2_pending),
        .rf_we       (rf_we),
        .rf_wreg     (rf_wreg),
        .rf_wdata    (rf_wdata),
        .fifo_count  (fifo_count)
    );

    task automatic idle_inputs();
        core_we = 0; core_wreg = 0; core_wdata = 0;
        aux_valid = 0; aux_wreg = 0; aux_wdata = 0;
        rd_reg1 = 0; rd_reg2 = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        next_cycle();
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            core_we = 1; core_wreg = 1; core_wdata = 32'(k);
            aux_valid = 1; aux_wreg = 5'(20 + k); aux_wdata = 32'h100 + 32'(k);
            next_cycle();
        end
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", fifo_count); end
        checks++;
        if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_rf_we got %b want 0", rf_we); end
        checks++;
        if (aux_ready !== 1'b0) begin errors++; $display("FAIL rst_aux_ready got %b want 0", aux_ready); end
        checks++;
        if (core_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", core_stall); end
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        #1;
        checks++;
        if (aux_ready !== 1'b1) begin errors++; $display("FAIL rel_aux_ready got %b want 1", aux_ready); end
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (rf_we !== 1'b0 || fifo_count !== 3'd0) begin
                errors++; $display("FAIL rel_stale we=%b count=%0d want 0/0", rf_we, fifo_count);
            end
        end
        next_cycle();
    endtask

    task automatic test_aux_simple();
        do_reset();
        aux_valid = 1; aux_wreg = 9; aux_wdata = 32'h0000_1234;
        @(negedge clk);
        checks++;
        if (aux_ready !== 1'b1 || rf_we !== 1'b0) begin
            errors++; $display("FAIL simple_accept ready=%b we=%b want 1/0", aux_ready, rf_we);
        end
        next_cycle();
        aux_valid = 0;
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b1 || rf_wreg !== 5'd9 || rf_wdata !== 32'h0000_1234) begin
            errors++;
            $display("FAIL simple_write we=%b reg=%0d data=%h want 1/9/00001234", rf_we, rf_wreg, rf_wdata);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd0) begin errors++; $display("FAIL simple_drain got %0d want 0", fifo_count); end
        next_cycle();
    endtask

    task automatic test_starvation();
        do_reset();
        core_we = 1; core_wreg = 1; core_wdata = 32'hC0C0_0001;
        for (int k = 0; k < 4; k++) begin
            aux_valid = 1; aux_wreg = 5'(20 + k); aux_wdata = 32'h200 + 32'(k);
            next_cycle();
        end
        aux_wreg = 30; aux_wdata = 32'hBAD0_0030;
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd4 || aux_ready !== 1'b0 || core_stall !== 1'b0) begin
            errors++;
            $display("FAIL starve_full count=%0d ready=%b stall=%b want 4/0/0", fifo_count, aux_ready, core_stall);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (core_stall !== 1'b1 || rf_we !== 1'b1 || rf_wreg !== 5'd20 || fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL starve_grant stall=%b we=%b reg=%0d count=%0d want 1/1/20/4",
                     core_stall, rf_we, rf_wreg, fifo_count);
        end
        next_cycle();
        aux_valid = 0;
        @(negedge clk);
        checks++;
        if (core_stall !== 1'b0 || rf_wreg !== 5'd1 || fifo_count !== 3'd3) begin
            errors++;
            $display("FAIL starve_clear stall=%b reg=%0d count=%0d want 0/1/3", core_stall, rf_wreg, fifo_count);
        end
        next_cycle();
    endtask

    task automatic test_kill();
        do_reset();
        rd_reg1 = 8;
        aux_valid = 1; aux_wreg = 8; aux_wdata = 32'h5555_5555;
        core_we = 1; core_wreg = 8; core_wdata = 32'h1111_1111;
        next_cycle();
        aux_valid = 0; core_wdata = 32'hAAAA_AAAA;
        @(negedge clk);
        checks++;
        if (rd1_pending !== 1'b1) begin errors++; $display("FAIL kill_same_cycle got %b want 1", rd1_pending); end
        next_cycle();
        core_we = 0;
        @(negedge clk);
        checks++;
        if (rd1_pending !== 1'b0 || rf_we !== 1'b0 || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL kill_pop pend=%b we=%b count=%0d want 0/0/1", rd1_pending, rf_we, fifo_count);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd0 || tb_rf[8] !== 32'hAAAA_AAAA) begin
            errors++; $display("FAIL kill_retain count=%0d r8=%h want 0/aaaaaaaa", fifo_count, tb_rf[8]);
        end
        next_cycle();
    endtask

    task automatic test_zero_reg();
        do_reset();
        aux_valid = 1; aux_wreg = 0; aux_wdata = 32'h77;
        @(negedge clk);
        checks++;
        if (aux_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %b want 1", aux_ready); end
        next_cycle();
        aux_valid = 1; aux_wreg = 12; aux_wdata = 32'h0000_C0DE;
        core_we = 1; core_wreg = 0; core_wdata = 32'hDEAD_DEAD;
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd0 || rf_we !== 1'b0) begin
            errors++; $display("FAIL zero_noentry count=%0d we=%b want 0/0", fifo_count, rf_we);
        end
        next_cycle();
        aux_valid = 0;
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b1 || rf_wreg !== 5'd12 || rf_wdata !== 32'h0000_C0DE || core_stall !== 1'b0) begin
            errors++;
            $display("FAIL zero_core_drain we=%b reg=%0d data=%h stall=%b want 1/12/0000c0de/0",
                     rf_we, rf_wreg, rf_wdata, core_stall);
        end
        next_cycle();
    endtask

    task automatic test_pending();
        do_reset();
        core_we = 1; core_wreg = 1; core_wdata = 32'h1;
        aux_valid = 1; aux_wreg = 10; aux_wdata = 32'hA;
        next_cycle();
        aux_wreg = 11; aux_wdata = 32'hB;
        next_cycle();
        aux_valid = 0; rd_reg1 = 10; rd_reg2 = 0;
        @(negedge clk);
        checks++;
        if (rd1_pending !== 1'b1 || rd2_pending !== 1'b0) begin
            errors++; $display("FAIL pend_q p1=%b p2=%b want 1/0", rd1_pending, rd2_pending);
        end
        rd_reg2 = 11;
        #1;
        checks++;
        if (rd2_pending !== 1'b1) begin errors++; $display("FAIL pend_r11 got %b want 1", rd2_pending); end
        next_cycle();
        core_we = 0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (rd1_pending !== 1'b0 || rd2_pending !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL pend_drained p1=%b p2=%b count=%0d want 0/0/0", rd1_pending, rd2_pending, fifo_count);
        end
        next_cycle();
    endtask

    // Reference: the queue holds accepted aux results in order; core results are younger.
    task automatic test_random();
        wb_entry_t mq[$];
        wb_entry_t ent;
        int        starve;
        int        n;
        bit        live, creq, sg, cg, pp, e_we, e_p1, e_p2;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        do_reset();
        mq.delete();
        starve = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            core_we    = ($urandom % 4) != 0;
            core_wreg  = 5'($urandom_range(0, 7));
            core_wdata = $urandom;
            aux_valid  = ($urandom % 2) != 0;
            aux_wreg   = 5'($urandom_range(0, 7));
            aux_wdata  = $urandom;
            rd_reg1    = 5'($urandom_range(0, 7));
            rd_reg2    = 5'($urandom_range(0, 7));
            @(negedge clk);
            n    = mq.size();
            live = (n > 0) && !mq[0].kill;
            creq = core_we && (core_wreg != 0);
            sg   = (starve == STARVE_MAX) && live;
            cg   = creq && !sg;
            pp   = sg || (!creq && n > 0);
            e_we = cg || (pp && live);
            e_reg  = cg ? core_wreg : (n > 0 ? mq[0].wreg : 5'd0);
            e_data = cg ? core_wdata : (n > 0 ? mq[0].wdata : 32'd0);
            e_p1 = 0;
            e_p2 = 0;
            foreach (mq[i]) begin
                if (!mq[i].kill && rd_reg1 != 0 && mq[i].wreg == rd_reg1) e_p1 = 1;
                if (!mq[i].kill && rd_reg2 != 0 && mq[i].wreg == rd_reg2) e_p2 = 1;
            end
            checks++;
            if (rf_we !== e_we) begin errors++; $display("FAIL rnd_we cyc %0d got %b want %b", cyc, rf_we, e_we); end
            if (e_we) begin
                checks++;
                if (rf_wreg !== e_reg || rf_wdata !== e_data) begin
                    errors++;
                    $display("FAIL rnd_wr cyc %0d got %0d/%h want %0d/%h", cyc, rf_wreg, rf_wdata, e_reg, e_data);
                end
            end
            checks++;
            if (core_stall !== sg) begin errors++; $display("FAIL rnd_stall cyc %0d got %b want %b", cyc, core_stall, sg); end
            checks++;
            if (aux_ready !== (n < DEPTH)) begin
                errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, aux_ready, n < DEPTH);
            end
            checks++;
            if (int'(fifo_count) != n) begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", cyc, fifo_count, n); end
            checks++;
            if (rd1_pending !== e_p1 || rd2_pending !== e_p2) begin
                errors++;
                $display("FAIL rnd_pend cyc %0d got %b%b want %b%b", cyc, rd1_pending, rd2_pending, e_p1, e_p2);
            end
            @(posedge clk);
            if (cg) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (mq[i].wreg == core_wreg) begin
                        ent = mq[i]; ent.kill = 1'b1; mq[i] = ent;
                    end
                end
            end
            if (pp) void'(mq.pop_front());
            if (aux_valid && n < DEPTH && aux_wreg != 0) begin
                mq.push_back('{wreg: aux_wreg, wdata: aux_wdata, kill: 1'b0});
            end
            if (pp || n == 0) starve = 0;
            else if (cg && live && starve < STARVE_MAX) starve++;
            #1;
        end
    endtask

    initial begin
        rst_n = 1;
        idle_inputs();
        test_reset();
        test_aux_simple();
        test_starvation();
        test_kill();
        test_zero_reg();
        test_pending();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
